// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register carrying a PC plus NCH data channels under valid/ready.
// SKID=1 adds a second entry so in_ready comes straight from a flop; SKID=0 is a single register.
module pipe_stage_buf #(
  parameter int          DATA_W   = 32,
  parameter int          NCH      = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          SKID     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [1:0]            dbg_state
);

  localparam int DW = NCH * DATA_W;

  // State encoding equals the number of held entries, so occupancy is the state itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL2 = 2'd2;

  // Handshake: a beat moves only in a cycle where valid and ready are both high on
  // the same side (push upstream, pop downstream); neither side may retract valid.
  logic [1:0]    state_q, state_d;
  logic [31:0]   m_pc_q, m_pc_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [31:0]   s_pc_q, s_pc_d;
  logic [DW-1:0] s_data_q, s_data_d;
  logic          push, pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_pc_d   = m_pc_q;
    m_data_d = m_data_q;
    s_pc_d   = s_pc_q;
    s_data_d = s_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d  = ST_ONE;
          m_pc_d   = in_pc;
          m_data_d = in_data;
        end
      end
      ST_ONE: begin
        if (push && (pop || SKID == 0)) begin
          m_pc_d   = in_pc;
          m_data_d = in_data;
        end else if (push) begin
          state_d  = ST_FULL2;
          s_pc_d   = in_pc;
          s_data_d = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        // Skid entry is always the younger beat; it moves up once the main entry leaves.
        if (pop) begin
          state_d  = ST_ONE;
          m_pc_d   = s_pc_q;
          m_data_d = s_data_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d  = ST_EMPTY;
      m_pc_d   = PC_RESET;
      m_data_d = '0;
      s_pc_d   = PC_RESET;
      s_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      m_pc_q   <= PC_RESET;
      m_data_q <= '0;
      s_pc_q   <= PC_RESET;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_pc_q   <= m_pc_d;
      m_data_q <= m_data_d;
      s_pc_q   <= s_pc_d;
      s_data_q <= s_data_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_d != ST_FULL2);
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Bubbles present a nop regardless of what the registers still hold.
  assign out_pc    = out_valid ? m_pc_q : PC_RESET;
  assign out_data  = out_valid ? m_data_q : '0;
  assign occupancy = state_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios on SKID=1 and SKID=0 builds, then a random
// valid/ready/flush run checked against an expected queue.
module tb_pipe_stage_buf;

  localparam int          DATA_W = 32;
  localparam int          NCH    = 4;
  localparam int          DW     = DATA_W * NCH;
  localparam logic [31:0] PCR    = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pc = 32'h0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [1:0]    dbg_state;

  logic          flush0 = 1'b0;
  logic          in_valid0 = 1'b0;
  logic          in_ready0;
  logic [31:0]   in_pc0 = 32'h0;
  logic [DW-1:0] in_data0 = '0;
  logic          out_valid0;
  logic          out_ready0 = 1'b0;
  logic [31:0]   out_pc0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occupancy0;
  logic [1:0]    dbg_state0;

  int checks = 0;
  int failures = 0;
  logic [32+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .NCH(NCH), .PC_RESET(PCR), .SKID(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .occupancy(occupancy), .dbg_state(dbg_state)
  );

  pipe_stage_buf #(.DATA_W(DATA_W), .NCH(NCH), .PC_RESET(PCR), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_pc(in_pc0), .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_pc(out_pc0), .out_data(out_data0), .occupancy(occupancy0), .dbg_state(dbg_state0)
  );

  function automatic logic [DW-1:0] mk_data(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0000, pc + 32'd2, ~pc, pc + 32'd1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_data  = mk_data(pc);
  endtask

  // Checks the SKID=1 outputs against one expected snapshot.
  task automatic expect_out(input string nm, input logic v, input logic [31:0] pc,
                            input logic [1:0] occ, input logic rdy);
    logic [31:0]   epc;
    logic [DW-1:0] edata;
    epc   = v ? pc : PCR;
    edata = v ? mk_data(pc) : '0;
    checks++;
    if (out_valid !== v || out_pc !== epc || out_data !== edata ||
        occupancy !== occ || in_ready !== rdy) begin
      failures++;
      $display("FAIL %s got v=%b pc=%h occ=%0d rdy=%b data=%h exp v=%b pc=%h occ=%0d rdy=%b data=%h",
               nm, out_valid, out_pc, occupancy, in_ready, out_data, v, epc, occ, rdy, edata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h0000_3040);
    out_ready = 1'b1;
    tick();
    tick();
    expect_out("reset_hold", 1'b0, PCR, 2'd0, 1'b1);
    checks++;
    if (out_valid0 !== 1'b0 || out_pc0 !== PCR || out_data0 !== '0 || occupancy0 !== 2'd0) begin
      failures++;
      $display("FAIL reset_skid0 got v=%b pc=%h occ=%0d exp v=0 pc=%h occ=0",
               out_valid0, out_pc0, occupancy0, PCR);
    end
    drive(1'b0, 32'h0);
    reset = 1'b0;
    tick();
    expect_out("reset_release", 1'b0, PCR, 2'd0, 1'b1);
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_3000);
    tick();
    expect_out("stream_0", 1'b1, 32'h0000_3000, 2'd1, 1'b1);
    drive(1'b1, 32'h0000_3004);
    tick();
    expect_out("stream_1", 1'b1, 32'h0000_3004, 2'd1, 1'b1);
    drive(1'b1, 32'h0000_3008);
    tick();
    expect_out("stream_2", 1'b1, 32'h0000_3008, 2'd1, 1'b1);
    drive(1'b0, 32'h0);
    tick();
    expect_out("stream_drain", 1'b0, PCR, 2'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_3020);
    tick();
    expect_out("bp_first", 1'b1, 32'h0000_3020, 2'd1, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_3024);
    tick();
    expect_out("bp_full", 1'b1, 32'h0000_3020, 2'd2, 1'b0);
    drive(1'b1, 32'h0000_3028);
    tick();
    expect_out("bp_hold1", 1'b1, 32'h0000_3020, 2'd2, 1'b0);
    tick();
    expect_out("bp_hold2", 1'b1, 32'h0000_3020, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    expect_out("bp_drain_skid", 1'b1, 32'h0000_3024, 2'd1, 1'b1);
    tick();
    expect_out("bp_refill", 1'b1, 32'h0000_3028, 2'd1, 1'b1);
    drive(1'b0, 32'h0);
    tick();
    expect_out("bp_empty", 1'b0, PCR, 2'd0, 1'b1);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_3030);
    tick();
    drive(1'b1, 32'h0000_3034);
    tick();
    expect_out("flush_pre_full", 1'b1, 32'h0000_3030, 2'd2, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h0000_3010);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    expect_out("flush_full", 1'b0, PCR, 2'd0, 1'b1);
    tick();
    expect_out("flush_no_ghost", 1'b0, PCR, 2'd0, 1'b1);
    // Flush with an accepted push at occupancy 1: the pushed beat must be discarded.
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_3040);
    tick();
    expect_out("flush1_pre", 1'b1, 32'h0000_3040, 2'd1, 1'b1);
    flush = 1'b1;
    drive(1'b1, 32'h0000_3010);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    expect_out("flush1_drop", 1'b0, PCR, 2'd0, 1'b1);
    tick();
    expect_out("flush1_no_ghost", 1'b0, PCR, 2'd0, 1'b1);
  endtask

  task automatic test_noskid();
    out_ready0 = 1'b0;
    in_valid0  = 1'b1;
    in_pc0     = 32'h0000_3050;
    in_data0   = mk_data(32'h0000_3050);
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL s0_empty_ready got=%b exp=1", in_ready0);
    end
    tick();
    in_pc0   = 32'h0000_3054;
    in_data0 = mk_data(32'h0000_3054);
    #1;
    checks++;
    if (in_ready0 !== 1'b0 || out_pc0 !== 32'h0000_3050 || occupancy0 !== 2'd1) begin
      failures++;
      $display("FAIL s0_full_stall got rdy=%b pc=%h occ=%0d exp rdy=0 pc=00003050 occ=1",
               in_ready0, out_pc0, occupancy0);
    end
    tick();
    checks++;
    if (out_pc0 !== 32'h0000_3050 || out_data0 !== mk_data(32'h0000_3050)) begin
      failures++;
      $display("FAIL s0_hold got pc=%h exp pc=00003050", out_pc0);
    end
    out_ready0 = 1'b1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL s0_pass_ready got=%b exp=1", in_ready0);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b1 || out_pc0 !== 32'h0000_3054 || occupancy0 !== 2'd1 ||
        out_data0 !== mk_data(32'h0000_3054)) begin
      failures++;
      $display("FAIL s0_replace got v=%b pc=%h occ=%0d exp v=1 pc=00003054 occ=1",
               out_valid0, out_pc0, occupancy0);
    end
    in_valid0 = 1'b0;
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || out_pc0 !== PCR || occupancy0 !== 2'd0 || out_data0 !== '0) begin
      failures++;
      $display("FAIL s0_empty got v=%b pc=%h occ=%0d exp v=0 pc=%h occ=0",
               out_valid0, out_pc0, occupancy0, PCR);
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_3060);
    tick();
    drive(1'b1, 32'h0000_3064);
    tick();
    expect_out("rst_stall_pre", 1'b1, 32'h0000_3060, 2'd2, 1'b0);
    reset = 1'b1;
    tick();
    expect_out("rst_stall", 1'b0, PCR, 2'd0, 1'b1);
    reset = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    expect_out("rst_stall_after", 1'b0, PCR, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    logic          do_push, do_pop;
    logic [32+DW-1:0] head;
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      in_pc     = in_valid ? $urandom : 'x;
      in_data   = in_valid ? {$urandom, $urandom, $urandom, $urandom} : 'x;
      #1;
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_pop_empty cycle=%0d got pc=%h exp no beat", c, out_pc);
        end else begin
          head = exp_q.pop_front();
          if ({out_pc, out_data} !== head) begin
            failures++;
            $display("FAIL rand_order cycle=%0d got pc=%h data=%h exp pc=%h data=%h",
                     c, out_pc, out_data, head[32+DW-1:DW], head[DW-1:0]);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (do_push) exp_q.push_back({in_pc, in_data});
      @(posedge clk);
      #1;
      checks++;
      if (occupancy !== 2'(exp_q.size()) || out_valid !== (exp_q.size() != 0) ||
          in_ready !== (exp_q.size() < 2)) begin
        failures++;
        $display("FAIL rand_occ cycle=%0d got occ=%0d v=%b rdy=%b exp occ=%0d",
                 c, occupancy, out_valid, in_ready, exp_q.size());
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    in_pc    = 32'h0;
    in_data  = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_noskid();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
